// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot producer path.
// Rotation helpers take the live width so one function serves every DW up to MAX_DW.
package onehot_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHL   = 2'd1,
        SHR   = 2'd2,
        QUERY = 2'd3
    } onehot_cmd_e;

    localparam int MAX_DW = 64;
    localparam int MAX_IW = 6;

    // Bits at or above w are forced to zero; the index cast keeps every select in range.
    function automatic logic [MAX_DW-1:0] rotl1(input logic [MAX_DW-1:0] v, input int w);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < w) begin
                r[i] = v[MAX_IW'((i == 0) ? (w - 1) : (i - 1))];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_DW-1:0] rotr1(input logic [MAX_DW-1:0] v, input int w);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < w) begin
                r[i] = v[MAX_IW'((i == w - 1) ? 0 : (i + 1))];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// Generic two-entry valid/ready buffer: main register plus a skid register.
// The skid entry always holds the older beat, so it is presented first.
module onehot_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic         ready_q, ready_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire_s;

    assign in_fire_s   = in_valid_i && ready_q;
    assign in_ready_o  = ready_q;
    assign out_valid_o = main_v_q || skid_v_q;
    assign out_data_o  = skid_v_q ? skid_q : main_q;

    // Occupancy transitions; ready follows the next-state skid flag so it is a flop output.
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        case ({skid_v_q, main_v_q})
            2'b00: begin
                if (in_fire_s) begin
                    main_v_d = 1'b1;
                    main_d   = in_data_i;
                end else begin
                    main_v_d = 1'b0;
                end
            end
            2'b01: begin
                if (in_fire_s && out_ready_i) begin
                    main_d = in_data_i;
                end else if (in_fire_s) begin
                    skid_v_d = 1'b1;
                    skid_d   = main_q;
                    main_d   = in_data_i;
                end else if (out_ready_i) begin
                    main_v_d = 1'b0;
                end else begin
                    main_v_d = 1'b1;
                end
            end
            default: begin
                if (out_ready_i) begin
                    skid_v_d = 1'b0;
                end else begin
                    skid_v_d = 1'b1;
                end
            end
        endcase
        ready_d = !skid_v_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/onehot_enc.sv
// Streaming one-hot producer: decodes commands into a one-hot state register
// and emits one {err, onehot} beat per accepted command through a skid buffer.
module onehot_enc
    import onehot_pkg::*;
#(
    parameter int  DW      = 8,
    parameter int  RST_IDX = 0,
    localparam int IW      = $clog2(DW)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [1:0]    cmd_i,
    input  logic [IW-1:0] idx_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] onehot_o,
    output logic          err_o
);

    localparam logic [DW-1:0] ONE_BIT    = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] RST_ONEHOT = ONE_BIT << RST_IDX;
    localparam logic [IW:0]   DW_LIM     = (IW+1)'(DW);

    onehot_cmd_e       cmd_s;
    logic [DW-1:0]     cur_q, cur_d;
    logic [DW-1:0]     nxt_s;
    logic              err_s;
    logic              accept_s;
    logic [MAX_DW-1:0] rot_s;
    logic [DW:0]       beat_s;

    assign accept_s = valid_i && ready_o;

    // Command decode; out-of-range LOAD keeps cur and flags the beat.
    always_comb begin
        cmd_s = onehot_cmd_e'(cmd_i);
        nxt_s = cur_q;
        err_s = 1'b0;
        rot_s = '0;
        case (cmd_s)
            LOAD: begin
                if ({1'b0, idx_i} < DW_LIM) begin
                    nxt_s = ONE_BIT << idx_i;
                end else begin
                    err_s = 1'b1;
                end
            end
            SHL: begin
                rot_s = rotl1(MAX_DW'(cur_q), DW);
                nxt_s = rot_s[DW-1:0];
            end
            SHR: begin
                rot_s = rotr1(MAX_DW'(cur_q), DW);
                nxt_s = rot_s[DW-1:0];
            end
            QUERY:   nxt_s = cur_q;
            default: nxt_s = cur_q;
        endcase
        cur_d = accept_s ? nxt_s : cur_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q <= RST_ONEHOT;
        end else begin
            cur_q <= cur_d;
        end
    end

    onehot_skid_buf #(.W(DW + 1)) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (valid_i),
        .in_ready_o  (ready_o),
        .in_data_i   ({err_s, nxt_s}),
        .out_valid_o (valid_o),
        .out_ready_i (ready_i),
        .out_data_o  (beat_s)
    );

    assign err_o    = beat_s[DW];
    assign onehot_o = beat_s[DW-1:0];

endmodule

// File: doc/onehot_enc.md
Name: onehot_enc

Overview:
- Streaming producer of one-hot codes; the generating end of the one-hot path whose checking end is onehot_det.
- Accepts commands over a valid/ready handshake and keeps a one-hot state register, `cur_r`.
- For every accepted command it emits one output beat carrying the updated one-hot word and an error flag.
- Feeds grant/select buses that downstream logic, and onehot_det in benches, check for one-hotness.

Parameters:
- DW, 8, width of the one-hot word; legal range 2..64.
- IW, $clog2(DW), index width; localparam derived from DW, not overridable.
- RST_IDX, 0, bit position set in `cur_r` at reset; must be < DW.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- valid_i  input  1  command valid.
- ready_o  output  1  command accepted when valid_i && ready_o.
- cmd_i  input  2  command, type onehot_cmd_e (LOAD, SHL, SHR, QUERY).
- idx_i  input  IW  bit index, used by LOAD only.
- valid_o  output  1  output beat valid.
- ready_i  input  1  downstream ready; beat transfers when valid_o && ready_i.
- onehot_o  output  DW  one-hot word.
- err_o  output  1  beat is the response to a rejected LOAD.

Behaviour:
- Reset (rst_i high at a clock edge):
  - cur_r = 1 << RST_IDX.
  - valid_o = 0, err_o = 0, onehot_o = 0, ready_o = 1.
  - Both buffer entries are emptied.
  - Reset mid-transfer drops any pending beats without emitting them.
- Commands, applied on acceptance; nxt is the new cur_r:
  - LOAD: if idx_i < DW then nxt = 1 << idx_i, err = 0. Otherwise nxt = cur_r, err = 1. This case only arises when DW is not a power of two.
  - SHL: rotate left by 1 with wrap, bit DW-1 -> bit 0. err = 0.
  - SHR: rotate right by 1 with wrap, bit 0 -> bit DW-1. err = 0.
  - QUERY: nxt = cur_r, err = 0.
- cur_r updates on the acceptance edge. Back-to-back commands chain on the updated value.
- Latency: a command accepted at edge N appears as {nxt, err} on onehot_o/err_o with valid_o = 1 after edge N, i.e. 1 cycle.
- Throughput is 1 beat/cycle while ready_i = 1.
- Output buffering is a two-entry skid buffer: main + skid register.
  - ready_o is a registered signal: ready_o = !skid_full.
  - An accept while main holds a beat and ready_i = 0 moves that beat into skid.
  - When ready_i returns, skid drains before main. Order is preserved and nothing is lost or duplicated.
- Invariants:
  - $onehot(onehot_o) == 1 whenever valid_o = 1, including error beats.
  - $onehot(cur_r) == 1 at all times after reset.
- Stable-while-stalled: while valid_o && !ready_i, onehot_o and err_o hold steady.
- Boundary conditions:
  - With the buffer full, ready_o = 0 and valid_i is ignored; cur_r is unchanged.
  - Accept and output transfer in the same cycle with the buffer full: ready_o is still 0 that cycle; ready_o rises the next cycle.
  - Simultaneous accept and transfer with one entry occupied: the buffer stays at one entry.
  - idx_i is ignored for SHL, SHR and QUERY.
- No combinational path from ready_i to ready_o, or from valid_i to valid_o.

Decomposition:
- Shared package onehot_pkg holds:
  - typedef enum logic [1:0] onehot_cmd_e, with LOAD = 0, SHL = 1, SHR = 2, QUERY = 3.
  - function rotl1/rotr1 parameterised by width.
- One sub-module: onehot_skid_buf.
  - Parameter W; generic two-entry valid/ready skid buffer.
  - Instantiated with W = DW+1 to carry {err, onehot}.
- Command decode and cur_r stay in onehot_enc.

Test Plan:
- Reset then QUERY with DW=8 and RST_IDX=0: one beat, onehot_o = 00000001, err_o = 0; ready_o = 1 in reset.
- LOAD idx=5, then SHL x3: beats 00100000, 01000000, 10000000, 00000001 (wrap). Then SHR gives 10000000.
- DW=6 (IW=3), after LOAD idx=2: LOAD idx=7 gives a beat with err_o = 1 and onehot_o = 000100 (unchanged); a following LOAD idx=5 gives 100000, err_o = 0.
- Backpressure: hold ready_i = 0 and issue SHL x3 from 00000001.
  - ready_o drops after two accepts; the third command waits.
  - Release ready_i: beats arrive in order 00000010, 00000100, then 00001000. No loss, no duplication, onehot_o stable while stalled.
- Reset asserted while two beats are buffered: the next cycle shows valid_o = 0, ready_o = 1 and cur_r = 00000001; the old beats never appear.
- Random regression: 1000 random commands with random ready_i.
  - onehot_det (MODE 0 and MODE 1) on onehot_o reports is_onehot_o = 1 on every valid beat.
  - A scoreboard model matches every beat.
